// File: rtl/divider_seq.sv
// Sequential restoring divider: 2*WIDTH-bit dividend by WIDTH-bit divisor,
// one quotient bit per cycle, with divide-by-zero and quotient-overflow detection.
module divider_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [2*WIDTH-1:0]   opN,
   input  logic [WIDTH-1:0]     opD,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     quo_reg,
   output logic [WIDTH-1:0]     rem_reg,
   output logic                 dz,
   output logic                 ovf
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [1:0]        state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0]  div_q, div_d;
   logic [WIDTH-1:0]  lo_q, lo_d;
   logic [WIDTH-1:0]  quo_q, quo_d;
   logic [WIDTH-1:0]  rem_q, rem_d;
   logic              dz_q, dz_d;
   logic              ovf_q, ovf_d;
   logic [WIDTH:0]    shifted;
   logic              exc;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      div_d   = div_q;
      lo_d    = lo_q;
      quo_d   = quo_q;
      rem_d   = rem_q;
      dz_d    = dz_q;
      ovf_d   = ovf_q;
      exc     = 1'b0;
      // Extra MSB keeps the carry-out of the shift so the compare stays exact
      shifted = {rem_q, lo_q[WIDTH-1]};

      case (state_q)
         IDLE: begin
            if (start) begin
               div_d = opD;
               lo_d  = opN[WIDTH-1:0];
               dz_d  = 1'b0;
               ovf_d = 1'b0;
               if (opD == '0) begin
                  dz_d = 1'b1;
                  exc  = 1'b1;
               end else if (opN[2*WIDTH-1:WIDTH] >= opD) begin
                  ovf_d = 1'b1;
                  exc   = 1'b1;
               end
               if (exc) begin
                  quo_d   = '1;
                  rem_d   = opN[WIDTH-1:0];
                  state_d = DONE;
               end else begin
                  quo_d   = '0;
                  rem_d   = opN[2*WIDTH-1:WIDTH];
                  cnt_d   = CntW'(WIDTH - 1);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            lo_d  = lo_q << 1;
            quo_d = quo_q << 1;
            if (shifted >= {1'b0, div_q}) begin
               // Difference is below the divisor, so it always fits in WIDTH bits
               rem_d    = shifted[WIDTH-1:0] - div_q;
               quo_d[0] = 1'b1;
            end else begin
               rem_d = shifted[WIDTH-1:0];
            end
            cnt_d = cnt_q - CntW'(1);
            if (cnt_q == '0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         lo_q    <= '0;
         quo_q   <= '0;
         rem_q   <= '0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         lo_q    <= lo_d;
         quo_q   <= quo_d;
         rem_q   <= rem_d;
         dz_q    <= dz_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign done    = (state_q == DONE);
   assign quo_reg = quo_q;
   assign rem_reg = rem_q;
   assign dz      = dz_q;
   assign ovf     = ovf_q;

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: expected results queued at start acceptance,
// popped and compared whenever done pulses.
module tb_divider_seq;

   localparam int unsigned WIDTH  = 32;
   localparam int          NBURST = 1000;

   logic                clk;
   logic                rst_n;
   logic                start;
   logic [2*WIDTH-1:0]  opN;
   logic [WIDTH-1:0]    opD;
   logic                busy;
   logic                done;
   logic [WIDTH-1:0]    quo_reg;
   logic [WIDTH-1:0]    rem_reg;
   logic                dz;
   logic                ovf;

   divider_seq #(.WIDTH(WIDTH)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .opN     (opN),
      .opD     (opD),
      .busy    (busy),
      .done    (done),
      .quo_reg (quo_reg),
      .rem_reg (rem_reg),
      .dz      (dz),
      .ovf     (ovf)
   );

   typedef struct {
      logic [WIDTH-1:0] q;
      logic [WIDTH-1:0] r;
      logic             dz;
      logic             ovf;
      int               lat;
      int               acc;
   } exp_t;

   exp_t             sb[$];
   int               total = 0;
   int               bad = 0;
   int               cyc = 0;
   int               busy_n = 0;
   int               last_done = 0;
   bit               have_last = 0;
   bit               burst = 0;
   logic [WIDTH-1:0] last_q = '0;
   logic [WIDTH-1:0] last_r = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model evaluated when the bench knows the next edge accepts start
   task automatic push(input logic [63:0] n, input logic [31:0] d);
      exp_t        e;
      logic [63:0] n_hi;
      e.acc = cyc + 1;
      n_hi  = n >> 32;
      e.dz  = 1'b0;
      e.ovf = 1'b0;
      if (d == 0) begin
         e.dz = 1'b1;
      end else if (n_hi >= {32'd0, d}) begin
         e.ovf = 1'b1;
      end
      if (e.dz || e.ovf) begin
         e.q   = '1;
         e.r   = n[31:0];
         e.lat = 1;
      end else begin
         e.q   = 32'(n / {32'd0, d});
         e.r   = 32'(n % {32'd0, d});
         e.lat = WIDTH + 1;
      end
      sb.push_back(e);
   endtask

   // Monitor: latency counted in rising edges from accept edge to the edge sampling done
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy_n = 0;
         end else begin
            if (busy) busy_n++;
            if (done) begin
               chk("sb_nonempty", sb.size() != 0, 1);
               if (sb.size() != 0) begin
                  e = sb.pop_front();
                  chk("quo", quo_reg, e.q);
                  chk("rem", rem_reg, e.r);
                  chk("dz", dz, e.dz);
                  chk("ovf", ovf, e.ovf);
                  chk("latency", (cyc + 1) - e.acc, e.lat);
                  chk("busy_cycles", busy_n, e.lat);
                  last_q = e.q;
                  last_r = e.r;
               end
               if (burst && have_last) chk("done_gap", cyc - last_done, WIDTH + 2);
               last_done = cyc;
               have_last = 1;
               busy_n    = 0;
            end
         end
      end
   end

   task automatic wait_idle();
      @(negedge clk);
      for (int i = 0; i < 100 && busy; i++) @(negedge clk);
      chk("idle_timeout", busy, 0);
   endtask

   task automatic drain(input int lim);
      for (int i = 0; i < lim && sb.size() != 0; i++) @(negedge clk);
      chk("drain", sb.size(), 0);
   endtask

   task automatic run_op(input logic [63:0] n, input logic [31:0] d);
      wait_idle();
      opN   = n;
      opD   = d;
      start = 1'b1;
      push(n, d);
      @(posedge clk);
      #1;
      start = 1'b0;
      opN   = {$urandom, $urandom};
      opD   = $urandom;
      drain(60);
   endtask

   task automatic rand_ops(input int i);
      logic [31:0] d;
      d = (i % 4 == 0) ? 32'($urandom_range(1, 255)) : $urandom;
      if (d == 0) d = 1;
      opD = d;
      opN = {$urandom % d, $urandom};
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_dz"}, dz, 0);
      chk({tag, "_ovf"}, ovf, 0);
      chk({tag, "_quo"}, quo_reg, 0);
      chk({tag, "_rem"}, rem_reg, 0);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      start = 1'b0;
      opN   = '0;
      opD   = '0;
      repeat (3) @(negedge clk);
      chk_cleared("reset");
      rst_n = 1'b1;

      run_op(64'd1035, 32'd23);
      run_op(64'd1000, 32'd7);
      run_op(64'd1088, 32'd0);
      run_op(64'h0000_0001_0000_0000, 32'd1);
      run_op({32'd22, 32'hFFFF_FFFF}, 32'd23);
      run_op({32'd23, 32'h0}, 32'd23);
      run_op(64'hFFFF_FFFE_FFFF_FFFF, 32'hFFFF_FFFF);
      run_op(64'd5, 32'd9);

      // Results must hold while idle with start low
      repeat (5) @(negedge clk);
      chk("hold_quo", quo_reg, last_q);
      chk("hold_rem", rem_reg, last_r);

      // Ignored start while busy, then reset mid-run
      wait_idle();
      opN   = 64'd1088;
      opD   = 32'd34;
      start = 1'b1;
      push(64'd1088, 32'd34);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(negedge clk);
      opN   = 64'd999_999;
      opD   = 32'd3;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk_cleared("midreset");
      sb.delete();
      repeat (2) @(negedge clk);
      chk_cleared("inreset");
      rst_n = 1'b1;
      run_op(64'd1088, 32'd34);
      chk("post_reset_quo", quo_reg, 32);
      chk("post_reset_rem", rem_reg, 0);

      // Back-to-back with start held high
      wait_idle();
      burst     = 1;
      have_last = 0;
      rand_ops(0);
      start = 1'b1;
      n     = 0;
      for (int i = 0; i < NBURST * 40 && n < NBURST; i++) begin
         if (!busy) begin
            push(opN, opD);
            n++;
            @(posedge clk);
            #1;
            if (n == NBURST) start = 1'b0;
            rand_ops(n);
         end
         @(negedge clk);
      end
      start = 1'b0;
      chk("burst_count", n, NBURST);
      drain(100);
      burst = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2_000_000;
      bad++;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
